// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Imported by the conditioner top and its synchroniser.
package button_pkg;

  typedef enum logic [1:0] {
    LOW,
    RISING,
    HIGH,
    FALLING
  } deb_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/button_conditioner_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// Every stage clears on reset so the output starts at 0.
module sync_ff #(
  parameter int STAGES = button_pkg::SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect a raw push button.
// btn_pulse fires once per accepted press, never on release.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_sync;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: begin
        if (btn_sync) begin
          state_d = RISING;
          cnt_d   = '0;
        end
      end
      RISING: begin
        if (!btn_sync) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!btn_sync) begin
          state_d = FALLING;
          cnt_d   = '0;
        end
      end
      FALLING: begin
        // A bounce back to 1 here is the same press, not a new one.
        if (btn_sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == HIGH) ||
              (state_d == FALLING);
    pulse_d = (state_q == RISING) &&
              (state_d == HIGH);
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule
